// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - ALU reservation station shared encodings and defaults
package alu_rs_pkg;

    localparam int RS_SIZE_DEF = 8;
    localparam int ROB_W_DEF   = 4;

    typedef enum logic [2:0] {
        OP_ADD_SUB = 3'b000,
        OP_SLL     = 3'b001,
        OP_SLT     = 3'b010,
        OP_SLTU    = 3'b011,
        OP_XOR     = 3'b100,
        OP_SRL_SRA = 3'b101,
        OP_OR      = 3'b110,
        OP_AND     = 3'b111
    } alu_op_l1_e;

    // Sub-op bit: selects the second flavour within ADD_SUB and SRL_SRA.
    typedef enum logic {
        L2_ADD_SRL = 1'b0,
        L2_SUB_SRA = 1'b1
    } alu_op_l2_e;

endpackage

// File: rtl/alu_rs_prio_enc.sv
// rtl/alu_rs_prio_enc.sv - lowest-index set-bit encoder with found flag
module rs_prio_enc #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
        end
    end

    assign found_o = |req_i;

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station: dispatch, CDB wake-up, in-order-by-index issue
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int ROB_W   = ROB_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispatch_valid,
    input  logic [2:0]        dispatch_op_l1,
    input  logic              dispatch_op_l2,
    input  logic [31:0]       dispatch_vj,
    input  logic [31:0]       dispatch_vk,
    input  logic              dispatch_qj_wait,
    input  logic              dispatch_qk_wait,
    input  logic [ROB_W-1:0]  dispatch_qj,
    input  logic [ROB_W-1:0]  dispatch_qk,
    input  logic [ROB_W-1:0]  dispatch_rob_id,
    output logic              full,
    input  logic              cdb_valid,
    input  logic [ROB_W-1:0]  cdb_rob_id,
    input  logic [31:0]       cdb_value,
    input  logic              flush,
    output logic              issue_valid,
    output logic [31:0]       issue_opr1,
    output logic [31:0]       issue_opr2,
    output logic [2:0]        issue_op_l1,
    output logic              issue_op_l2,
    output logic [ROB_W-1:0]  issue_rob_id
);

    localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_q;
    logic [RS_SIZE-1:0] wj_q;
    logic [RS_SIZE-1:0] wk_q;
    logic [RS_SIZE-1:0] op_l2_q;
    logic [2:0]         op_l1_q [RS_SIZE];
    logic [31:0]        vj_q    [RS_SIZE];
    logic [31:0]        vk_q    [RS_SIZE];
    logic [ROB_W-1:0]   qj_q    [RS_SIZE];
    logic [ROB_W-1:0]   qk_q    [RS_SIZE];
    logic [ROB_W-1:0]   rob_q   [RS_SIZE];

    logic               iss_valid_q;
    logic [31:0]        iss_opr1_q;
    logic [31:0]        iss_opr2_q;
    logic [2:0]         iss_op_l1_q;
    logic               iss_op_l2_q;
    logic [ROB_W-1:0]   iss_rob_q;

    logic [RS_SIZE-1:0] ready;
    logic [IW-1:0]      free_idx;
    logic [IW-1:0]      iss_idx;
    logic               free_found;
    logic               iss_found;
    logic               accept;
    logic               disp_j_hit;
    logic               disp_k_hit;
    logic [31:0]        disp_vj_d;
    logic [31:0]        disp_vk_d;

    // Eligibility looks only at registered state, so a wake-up issues one edge later.
    always_comb begin
        ready = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy_q[i] & ~wj_q[i] & ~wk_q[i];
        end
    end

    rs_prio_enc #(.N(RS_SIZE), .W(IW)) u_free_enc (
        .req_i   (~busy_q),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    rs_prio_enc #(.N(RS_SIZE), .W(IW)) u_issue_enc (
        .req_i   (ready),
        .idx_o   (iss_idx),
        .found_o (iss_found)
    );

    assign full   = &busy_q;
    assign accept = dispatch_valid & free_found & ~flush;

    always_comb begin
        disp_j_hit = dispatch_qj_wait & cdb_valid & (dispatch_qj == cdb_rob_id);
        disp_k_hit = dispatch_qk_wait & cdb_valid & (dispatch_qk == cdb_rob_id);
        disp_vj_d  = disp_j_hit ? cdb_value : dispatch_vj;
        disp_vk_d  = disp_k_hit ? cdb_value : dispatch_vk;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= '0;
            wj_q        <= '0;
            wk_q        <= '0;
            op_l2_q     <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_l1_q[i] <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                rob_q[i]   <= '0;
            end
            iss_valid_q <= 1'b0;
            iss_opr1_q  <= '0;
            iss_opr2_q  <= '0;
            iss_op_l1_q <= '0;
            iss_op_l2_q <= 1'b0;
            iss_rob_q   <= '0;
        end else if (flush) begin
            busy_q      <= '0;
            iss_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && cdb_valid) begin
                    if (wj_q[i] && qj_q[i] == cdb_rob_id) begin
                        vj_q[i] <= cdb_value;
                        wj_q[i] <= 1'b0;
                    end
                    if (wk_q[i] && qk_q[i] == cdb_rob_id) begin
                        vk_q[i] <= cdb_value;
                        wk_q[i] <= 1'b0;
                    end
                end
            end

            iss_valid_q <= iss_found;
            if (iss_found) begin
                iss_opr1_q      <= vj_q[iss_idx];
                iss_opr2_q      <= vk_q[iss_idx];
                iss_op_l1_q     <= op_l1_q[iss_idx];
                iss_op_l2_q     <= op_l2_q[iss_idx];
                iss_rob_q       <= rob_q[iss_idx];
                busy_q[iss_idx] <= 1'b0;
            end

            // The free slot is never the issuing one, so both writes can land together.
            if (accept) begin
                busy_q[free_idx]  <= 1'b1;
                op_l1_q[free_idx] <= dispatch_op_l1;
                op_l2_q[free_idx] <= dispatch_op_l2;
                vj_q[free_idx]    <= disp_vj_d;
                vk_q[free_idx]    <= disp_vk_d;
                wj_q[free_idx]    <= dispatch_qj_wait & ~disp_j_hit;
                wk_q[free_idx]    <= dispatch_qk_wait & ~disp_k_hit;
                qj_q[free_idx]    <= dispatch_qj;
                qk_q[free_idx]    <= dispatch_qk;
                rob_q[free_idx]   <= dispatch_rob_id;
            end
        end
    end

    assign issue_valid  = iss_valid_q;
    assign issue_opr1   = iss_opr1_q;
    assign issue_opr2   = iss_opr2_q;
    assign issue_op_l1  = iss_op_l1_q;
    assign issue_op_l2  = iss_op_l2_q;
    assign issue_rob_id = iss_rob_q;

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of station entries (power of two, 2..16).
REQ-002 SHALL have parameter ROB_W, default 4, width of ROB tags.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port dispatch_valid  in  1  decoder offers one ALU instruction.
REQ-006 SHALL have ports dispatch_op_l1  in  3 and dispatch_op_l2  in  1  ALU op class and sub-op.
REQ-007 SHALL have ports dispatch_vj, dispatch_vk  in  32  operand values, meaningful when not waiting.
REQ-008 SHALL have ports dispatch_qj_wait, dispatch_qk_wait  in  1  operand awaits a producer.
REQ-009 SHALL have ports dispatch_qj, dispatch_qk  in  ROB_W  producer tags.
REQ-010 SHALL have port dispatch_rob_id  in  ROB_W  destination tag.
REQ-011 SHALL have port full  out  1  no free entry; dispatch refused.
REQ-012 SHALL have ports cdb_valid  in  1, cdb_rob_id  in  ROB_W, cdb_value  in  32  result broadcast.
REQ-013 SHALL have port flush  in  1  mispredict squash.
REQ-014 SHALL have ports issue_valid  out  1, issue_opr1, issue_opr2  out  32, issue_op_l1  out  3, issue_op_l2  out  1, issue_rob_id  out  ROB_W  registered request to the ALU.

Function
REQ-015 Dispatch SHALL be accepted iff dispatch_valid=1, full=0, flush=0; written into lowest-index free entry.
REQ-016 An accepted operand whose wait bit is 1 and whose tag equals cdb_rob_id while cdb_valid=1 in the same cycle SHALL be stored ready with cdb_value (same-cycle bypass).
REQ-017 Each cycle, every busy entry waiting on tag cdb_rob_id with cdb_valid=1 SHALL capture cdb_value and clear its wait bit; both operands may wake in one cycle.
REQ-018 Entry SHALL be issue-eligible when busy and both operands ready, evaluated from registered state; wake-up in cycle N gives earliest issue_valid at edge ending cycle N+1.
REQ-019 Each cycle at most one eligible entry SHALL be selected, lowest index first; at the edge its fields load issue_* with issue_valid=1 and the entry is freed.
REQ-020 With no eligible entry, issue_valid SHALL be 0 the following cycle; issue_* data holds last value.
REQ-021 Latency: fully-ready dispatch at edge E SHALL produce issue_valid=1 after edge E+1 (one cycle in station).
REQ-022 full SHALL be combinational from busy bits: 1 iff all RS_SIZE entries busy; issue freeing a slot at edge E clears full after E, dispatch in that same cycle still refused.
REQ-023 Simultaneous dispatch and issue into/out of different entries SHALL both take effect at one edge.
REQ-024 flush=1 SHALL clear all busy bits and force issue_valid=0 at the next edge; dispatch and CDB ignored that cycle.
REQ-025 Operand values SHALL pass unmodified (no width change); immediates are pre-placed in vk by decoder.

Reset
REQ-026 rst=0 SHALL immediately clear all busy bits, issue_valid=0, issue_opr1/opr2=0, issue_op_l1=0, issue_op_l2=0, issue_rob_id=0, hence full=0.
REQ-027 Reset asserted mid-operation SHALL discard all entries; no issue occurs until a new dispatch after release.

Structure
REQ-028 Shared package SHALL hold ALU op encodings (ADD_SUB=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL_SRA=101, OR=110, AND=111; L2: ADD/SRL=0, SUB/SRA=1), ROB_W and RS_SIZE defaults.
REQ-029 One sub-module rs_prio_enc (lowest-index-set-bit encoder with found flag) SHALL be instantiated twice: free-slot select and issue select.

Verification
REQ-030 Dispatch op 000/0, vj=5, vk=7, both ready, rob 3 -> next cycle issue_valid=1, opr1=5, opr2=7, op_l1=000, rob_id=3.
REQ-031 Dispatch qj_wait=1 tag 2, vk=1; two cycles later CDB tag 2 value 0x10 -> issue_valid=1 one cycle after broadcast, opr1=0x10.
REQ-032 Dispatch qj_wait=1 tag 4 while CDB tag 4 value 9 same cycle -> next cycle issue opr1=9.
REQ-033 Dispatch 8 entries all waiting tag 6 -> full=1, ninth dispatch dropped; CDB tag 6 -> entries 0..7 issue on 8 consecutive cycles in index order, full=0 after first issue.
REQ-034 Three busy waiting entries, flush=1 -> next cycle full=0, issue_valid=0; later CDB on their tags produces no issue.
REQ-035 Assert rst=0 asynchronously mid-cycle with ready entry -> issue_valid=0 immediately, no issue after release.
